// File: rtl/guest_ctrl_pkg.sv
// Shared types for the guest core reset / clock-enable controller:
// reset-sequencer states and the reset-cause encoding.
package guest_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam logic [2:0] CAUSE_POR = 3'd0;
  localparam logic [2:0] CAUSE_EXT = 3'd1;
  localparam logic [2:0] CAUSE_DL  = 3'd2;
  localparam logic [2:0] CAUSE_OSD = 3'd3;
  localparam logic [2:0] CAUSE_CFG = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a
// selectable value forced while the block is in reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/guest_reset_ce_ctrl.sv
// Power-of-two clock-enable generator and stretched core-reset sequencer
// for guest cores; also reports the last reset cause and an event count.
module guest_reset_ce_ctrl
  import guest_ctrl_pkg::*;
#(
  parameter int DIV_W    = 4,
  parameter int NUM_CE   = 2,
  parameter int CFG_W    = 32,
  parameter int RST_HOLD = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ext_reset_n_i,
  input  logic              osd_reset_i,
  input  logic [CFG_W-1:0]  cfg_i,
  input  logic [CFG_W-1:0]  cfg_mask_i,
  input  logic              dl_active_i,
  input  logic [7:0]        dl_index_i,
  input  logic [7:0]        dl_reset_index_i,
  output logic [NUM_CE-1:0] ce_o,
  output logic              core_reset_o,
  output logic              core_reset_n_o,
  output logic              por_done_o,
  output logic [2:0]        cause_o,
  output logic [7:0]        evt_cnt_o
);

  localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RST_HOLD - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [NUM_CE-1:0] ce_q, ce_d;
  logic [CFG_W-1:0]  cfg_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_reset_q;
  logic              por_q, por_d;
  logic [2:0]        cause_q, cause_d;
  logic [7:0]        evt_q, evt_d;
  logic              ext_n_sync;
  logic              t_ext, t_osd, t_dl, t_cfg, any_t;
  logic              enter_assert;

  sync_2ff #(.RST_VAL(1'b1)) u_ext_sync (
    .clk_i (clk_sys),
    .rst_i (reset),
    .d_i   (ext_reset_n_i),
    .q_o   (ext_n_sync)
  );

  assign t_ext = ~ext_n_sync;
  assign t_osd = osd_reset_i;
  assign t_dl  = dl_active_i && (dl_index_i == dl_reset_index_i);
  assign t_cfg = |((cfg_i ^ cfg_q) & cfg_mask_i);
  assign any_t = t_ext | t_osd | t_dl | t_cfg;

  // ce_o[k] fires when the low k+1 divider bits are all zero.
  always_comb begin
    div_d = div_q + 1'b1;
    ce_d  = '0;
    for (int k = 0; k < NUM_CE; k++) begin
      ce_d[k] = ((div_q & DIV_W'((1 << (k + 1)) - 1)) == '0);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_assert = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        if (!any_t) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (any_t) begin
          state_d      = ST_ASSERT;
          enter_assert = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (any_t) begin
          state_d      = ST_ASSERT;
          enter_assert = 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_INIT;
      end
    endcase
  end

  // Cause is only refreshed on entry; staying in ASSERT absorbs new triggers.
  always_comb begin
    cause_d = cause_q;
    if (enter_assert) begin
      if (t_ext)      cause_d = CAUSE_EXT;
      else if (t_dl)  cause_d = CAUSE_DL;
      else if (t_osd) cause_d = CAUSE_OSD;
      else            cause_d = CAUSE_CFG;
    end
    evt_d = evt_q;
    if ((state_q == ST_RUN) && any_t && (evt_q != 8'hFF)) begin
      evt_d = evt_q + 8'd1;
    end
    por_d = por_q | (state_d == ST_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q        <= '0;
      ce_q         <= '0;
      cfg_q        <= cfg_i;
      state_q      <= ST_HOLD;
      cnt_q        <= HOLD_INIT;
      core_reset_q <= 1'b1;
      por_q        <= 1'b0;
      cause_q      <= CAUSE_POR;
      evt_q        <= '0;
    end else begin
      div_q        <= div_d;
      ce_q         <= ce_d;
      cfg_q        <= cfg_i;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_reset_q <= (state_d != ST_RUN);
      por_q        <= por_d;
      cause_q      <= cause_d;
      evt_q        <= evt_d;
    end
  end

  assign ce_o           = ce_q;
  assign core_reset_o   = core_reset_q;
  assign core_reset_n_o = ~core_reset_q;
  assign por_done_o     = por_q;
  assign cause_o        = cause_q;
  assign evt_cnt_o      = evt_q;

endmodule

// File: tb/tb_guest_reset_ce_ctrl.sv
// Bench for guest_reset_ce_ctrl: drives reset sources, measures each core
// reset pulse length against an expected queue, and checks status outputs.
module tb_guest_reset_ce_ctrl;

  logic        clk_sys;
  logic        reset;
  logic        ext_reset_n_i;
  logic        osd_reset_i;
  logic [31:0] cfg_i;
  logic [31:0] cfg_mask_i;
  logic        dl_active_i;
  logic [7:0]  dl_index_i;
  logic [7:0]  dl_reset_index_i;
  logic [1:0]  ce_o;
  logic        core_reset_o;
  logic        core_reset_n_o;
  logic        por_done_o;
  logic [2:0]  cause_o;
  logic [7:0]  evt_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int run_len  = 0;
  int exp_evt  = 0;
  logic [15:0] exp_q[$];

  guest_reset_ce_ctrl #(
    .DIV_W(4), .NUM_CE(2), .CFG_W(32), .RST_HOLD(16)
  ) dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .ext_reset_n_i    (ext_reset_n_i),
    .osd_reset_i      (osd_reset_i),
    .cfg_i            (cfg_i),
    .cfg_mask_i       (cfg_mask_i),
    .dl_active_i      (dl_active_i),
    .dl_index_i       (dl_index_i),
    .dl_reset_index_i (dl_reset_index_i),
    .ce_o             (ce_o),
    .core_reset_o     (core_reset_o),
    .core_reset_n_o   (core_reset_n_o),
    .por_done_o       (por_done_o),
    .cause_o          (cause_o),
    .evt_cnt_o        (evt_cnt_o)
  );

  // Clock / reset block
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check_core(input string tag, input logic exp_v);
    check(tag, {31'd0, core_reset_o}, {31'd0, exp_v});
    check({tag, "_n"}, {31'd0, core_reset_n_o}, {31'd0, ~exp_v});
  endtask

  task automatic osd_pulse();
    exp_q.push_back(16'd17);
    osd_reset_i = 1'b1;
    tick(1);
    osd_reset_i = 1'b0;
  endtask

  // Scoreboard: each completed core reset pulse is compared to the queue head.
  always @(negedge clk_sys) begin
    if (reset) begin
      run_len = 0;
    end else if (core_reset_o === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) check("unexpected_pulse", run_len, 0);
      else                   check("pulse_len", run_len, {16'd0, exp_q.pop_front()});
      run_len = 0;
    end
  end

  initial begin
    reset            = 1'b1;
    ext_reset_n_i    = 1'b1;
    osd_reset_i      = 1'b0;
    cfg_i            = 32'h0;
    cfg_mask_i       = 32'h0;
    dl_active_i      = 1'b0;
    dl_index_i       = 8'd0;
    dl_reset_index_i = 8'd0;

    // Reset state
    tick(3);
    check_core("rst_core", 1'b1);
    check("rst_ce", {30'd0, ce_o}, 0);
    check("rst_por", {31'd0, por_done_o}, 0);
    check("rst_cause", {29'd0, cause_o}, 0);
    check("rst_evt", {24'd0, evt_cnt_o}, 0);

    // Power-on: reset stretch of 16, enables run throughout
    exp_q.push_back(16'd16);
    reset = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      tick(1);
      check("ce0", {31'd0, ce_o[0]}, {31'd0, ((n - 1) % 2) == 0});
      check("ce1", {31'd0, ce_o[1]}, {31'd0, ((n - 1) % 4) == 0});
      if (n == 15) begin
        check_core("por_core_hi", 1'b1);
        check("por_done_lo", {31'd0, por_done_o}, 0);
      end
      if (n == 16) begin
        check_core("por_core_lo", 1'b0);
        check("por_done_hi", {31'd0, por_done_o}, 1);
      end
    end
    check("por_cause", {29'd0, cause_o}, 0);
    check("por_evt", {24'd0, evt_cnt_o}, 0);

    // Masked cfg bit changes nothing; unmasked bit gives a 17-cycle reset
    cfg_mask_i = 32'h7;
    tick(2);
    cfg_i = 32'h20;
    tick(25);
    check_core("cfg_masked", 1'b0);
    exp_q.push_back(16'd17);
    cfg_i = 32'h22;
    tick(1);
    exp_evt++;
    check_core("cfg_hit", 1'b1);
    check("cfg_cause", {29'd0, cause_o}, 4);
    check("cfg_evt", {24'd0, evt_cnt_o}, exp_evt);
    tick(25);
    check_core("cfg_done", 1'b0);

    // Download: non-matching index ignored, matching index holds reset
    dl_reset_index_i = 8'd1;
    dl_index_i       = 8'd2;
    dl_active_i      = 1'b1;
    tick(20);
    check_core("dl_nomatch", 1'b0);
    exp_q.push_back(16'd116);
    dl_index_i = 8'd1;
    tick(100);
    exp_evt++;
    check_core("dl_held", 1'b1);
    check("dl_cause", {29'd0, cause_o}, 2);
    dl_index_i = 8'd2;
    tick(25);
    check_core("dl_done", 1'b0);
    check("dl_evt", {24'd0, evt_cnt_o}, exp_evt);
    dl_active_i = 1'b0;

    // External button (2-cycle sync) with OSD, then OSD retrigger in HOLD
    exp_q.push_back(16'd27);
    ext_reset_n_i = 1'b0;
    tick(2);
    check_core("ext_sync_lag", 1'b0);
    osd_reset_i = 1'b1;
    tick(1);
    exp_evt++;
    check_core("ext_hit", 1'b1);
    check("ext_cause", {29'd0, cause_o}, 1);
    tick(2);
    ext_reset_n_i = 1'b1;
    tick(2);
    osd_reset_i = 1'b0;
    tick(5);
    osd_reset_i = 1'b1;
    tick(1);
    osd_reset_i = 1'b0;
    check("retrig_cause", {29'd0, cause_o}, 3);
    tick(30);
    check_core("ext_done", 1'b0);
    check("ext_evt", {24'd0, evt_cnt_o}, exp_evt);

    // Event counter saturation
    for (int i = 0; i < 300; i++) begin
      osd_pulse();
      tick(25);
      if (i == 99) check("evt_mid", {24'd0, evt_cnt_o}, exp_evt + 100);
    end
    check("evt_sat", {24'd0, evt_cnt_o}, 255);
    check("sat_cause", {29'd0, cause_o}, 3);

    // Synchronous reset clears status
    reset = 1'b1;
    tick(2);
    check("rst2_evt", {24'd0, evt_cnt_o}, 0);
    check("rst2_cause", {29'd0, cause_o}, 0);
    check("rst2_por", {31'd0, por_done_o}, 0);
    check_core("rst2_core", 1'b1);
    exp_q.push_back(16'd16);
    reset = 1'b0;
    tick(20);
    check_core("rst2_done", 1'b0);
    check("rst2_por_done", {31'd0, por_done_o}, 1);

    check("pending_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
